// File: rtl/keypad_event_queue.sv
// keypad_event_queue: frame-tick key matrix sampler with per-key debounce,
// a show-ahead press/release event FIFO, debounced key state and a release
// trigger for wait-for-key instructions.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (single-key autorepeat tracker).
module keypad_event_queue #(
    parameter int NUM_KEYS       = 16,
    parameter int IDX_W          = 4,
    parameter int DEBOUNCE_TICKS = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int REPEAT_DELAY   = 30,
    parameter int REPEAT_RATE    = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [NUM_KEYS-1:0] keypad_matrix,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                any_down,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic                evt_pressed,
    output logic                evt_repeat,
    output logic [IDX_W-1:0]    evt_index,
    output logic                release_trigger,
    output logic [IDX_W-1:0]    release_index,
    output logic                overflow,
    output logic                overrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = 4;
    localparam int EW = IDX_W + 2;
    localparam logic [CW-1:0]    DEB_LAST = CW'(DEBOUNCE_TICKS - 1);
    localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(NUM_KEYS - 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    k_q, k_d;
    logic [NUM_KEYS-1:0] snap_q, key_state_q;
    logic [CW-1:0]       cnt_q [NUM_KEYS];
    logic                rel_trig_q;
    logic [IDX_W-1:0]    rel_idx_q;
    logic                overflow_q, overrun_q;

    logic [EW-1:0]       mem_q [FIFO_DEPTH];
    logic [AW:0]         wr_q, rd_q;

    logic sweeping, differ, flip, new_level;
    logic rep_push;
    logic [IDX_W-1:0] rep_idx;
    logic push_v, pop, do_push, drop, empty, full;
    logic [EW-1:0] push_data, head;

    assign sweeping  = (state_q == SWEEP);
    assign new_level = snap_q[k_q];
    assign differ    = sweeping && (new_level != key_state_q[k_q]);
    assign flip      = differ && (cnt_q[k_q] == DEB_LAST);

    // Next-state logic of the sweep FSM: one key per cycle, ticks during a sweep are ignored
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE: if (tick) begin
                state_d = SWEEP;
                k_d     = '0;
            end
            SWEEP: begin
                if (k_q == K_LAST) state_d = IDLE;
                else               k_d     = k_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM registers, snapshot latch and overrun flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            snap_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            if (state_q == IDLE && tick) snap_q <= keypad_matrix;
            if (sweeping && tick) overrun_q <= 1'b1;
        end
    end

    // Debounce: count consecutive differing samples, flip the key when the count completes
    always_ff @(posedge clk) begin
        if (reset) begin
            key_state_q <= '0;
            for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
            rel_trig_q  <= 1'b0;
            rel_idx_q   <= '0;
        end else begin
            rel_trig_q <= 1'b0;
            if (sweeping) begin
                if (!differ) begin
                    cnt_q[k_q] <= '0;
                end else if (flip) begin
                    key_state_q[k_q] <= new_level;
                    cnt_q[k_q]       <= '0;
                    if (!new_level) begin
                        rel_trig_q <= 1'b1;
                        rel_idx_q  <= k_q;
                    end
                end else begin
                    cnt_q[k_q] <= cnt_q[k_q] + 1'b1;
                end
            end
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] R_DELAY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] R_RATE  = RW'(REPEAT_RATE);

    logic             rep_valid_q, rep_first_q, rep_pend_q, sweep_done_q;
    logic [IDX_W-1:0] rep_idx_q;
    logic [RW-1:0]    rep_cnt_q, rep_cnt_n;

    assign rep_cnt_n = rep_cnt_q + 1'b1;
    assign rep_idx   = rep_idx_q;
    // A due repeat is emitted in the idle cycle right after the sweep finishes
    assign rep_push  = (state_q == IDLE) && sweep_done_q && rep_pend_q && rep_valid_q;

    // Repeat tracker: follows the newest press, counts ticks while it stays down
    always_ff @(posedge clk) begin
        if (reset) begin
            rep_valid_q  <= 1'b0;
            rep_first_q  <= 1'b0;
            rep_pend_q   <= 1'b0;
            sweep_done_q <= 1'b0;
            rep_idx_q    <= '0;
            rep_cnt_q    <= '0;
        end else begin
            sweep_done_q <= sweeping && (k_q == K_LAST);
            if (flip && new_level) begin
                rep_valid_q <= 1'b1;
                rep_idx_q   <= k_q;
                rep_cnt_q   <= '0;
                rep_first_q <= 1'b0;
                rep_pend_q  <= 1'b0;
            end else if (flip && !new_level && rep_valid_q && k_q == rep_idx_q) begin
                rep_valid_q <= 1'b0;
                rep_pend_q  <= 1'b0;
            end else begin
                if (rep_push) rep_pend_q <= 1'b0;
                if (state_q == IDLE && tick && rep_valid_q) begin
                    if (rep_cnt_n == (rep_first_q ? R_RATE : R_DELAY)) begin
                        rep_cnt_q   <= '0;
                        rep_first_q <= 1'b1;
                        rep_pend_q  <= 1'b1;
                    end else begin
                        rep_cnt_q <= rep_cnt_n;
                    end
                end
            end
        end
    end
`else
    assign rep_push = 1'b0;
    assign rep_idx  = '0;
`endif

    // Sweep pushes and repeat pushes never coincide: repeats only fire in IDLE
    assign push_v    = flip || rep_push;
    assign push_data = flip ? {new_level, 1'b0, k_q} : {1'b1, 1'b1, rep_idx};
    assign empty     = (wr_q == rd_q);
    assign full      = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    assign pop       = !empty && evt_ready;
    assign do_push   = push_v && (!full || pop);
    assign drop      = push_v && full && !pop;

    // Event FIFO storage, pointers and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q       <= '0;
            rd_q       <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= push_data;
                wr_q                <= wr_q + 1'b1;
            end
            if (pop)  rd_q       <= rd_q + 1'b1;
            if (drop) overflow_q <= 1'b1;
        end
    end

    assign head            = empty ? '0 : mem_q[rd_q[AW-1:0]];
    assign evt_valid       = !empty;
    assign evt_pressed     = head[EW-1];
`ifdef KEYPAD_AUTOREPEAT_EN
    assign evt_repeat      = head[EW-2];
`else
    assign evt_repeat      = 1'b0;
`endif
    assign evt_index       = head[IDX_W-1:0];
    assign key_state       = key_state_q;
    assign any_down        = |key_state_q;
    assign release_trigger = rel_trig_q;
    assign release_index   = rel_idx_q;
    assign overflow        = overflow_q;
    assign overrun         = overrun_q;
endmodule

// File: tb/tb_keypad_event_queue.sv
// Testbench for keypad_event_queue: directed stimulus, expected events queued
// by the stimulus thread and checked by an independent monitor on pop.
module tb_keypad_event_queue;
    localparam int NUM_KEYS = 16;
    localparam int IDX_W    = 4;

    typedef struct packed {
        logic             pressed;
        logic             rpt;
        logic [IDX_W-1:0] idx;
    } evt_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                tick = 1'b0;
    logic [NUM_KEYS-1:0] keypad_matrix = '0;
    logic [NUM_KEYS-1:0] key_state;
    logic                any_down, evt_valid, evt_pressed, evt_repeat;
    logic                evt_ready = 1'b1;
    logic [IDX_W-1:0]    evt_index, release_index;
    logic                release_trigger, overflow, overrun;

    int   tests = 0;
    int   fails = 0;
    int   rel_cnt = 0;
    evt_t exp_q[$];

    keypad_event_queue #(
        .NUM_KEYS(NUM_KEYS), .IDX_W(IDX_W), .DEBOUNCE_TICKS(2),
        .FIFO_DEPTH(4), .REPEAT_DELAY(30), .REPEAT_RATE(6)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .keypad_matrix(keypad_matrix),
        .key_state(key_state), .any_down(any_down), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_pressed(evt_pressed), .evt_repeat(evt_repeat),
        .evt_index(evt_index), .release_trigger(release_trigger),
        .release_index(release_index), .overflow(overflow), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_evt(input logic p, input logic r, input int idx);
        evt_t e;
        e.pressed = p;
        e.rpt     = r;
        e.idx     = IDX_W'(idx);
        exp_q.push_back(e);
    endtask

    task automatic do_tick();
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        repeat (NUM_KEYS + 3) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    // Monitor: every handshake pops the next expected event and compares it
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            evt_t got, want;
            got = {evt_pressed, evt_repeat, evt_index};
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL evt_unexpected: got p=%0b r=%0b idx=%0d, expected none",
                         got.pressed, got.rpt, got.idx);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    fails++;
                    $display("FAIL evt: got p=%0b r=%0b idx=%0d expected p=%0b r=%0b idx=%0d",
                             got.pressed, got.rpt, got.idx, want.pressed, want.rpt, want.idx);
                end
            end
        end
    end

    // Count release pulses
    always @(negedge clk) begin
        if (!reset && release_trigger) rel_cnt++;
    end

    initial begin
        int rel0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_key_state", 64'(key_state), 64'h0);
        chk("rst_evt_valid", 64'(evt_valid), 64'h0);
        chk("rst_evt_fields", 64'({evt_pressed, evt_repeat, evt_index}), 64'h0);
        chk("rst_release", 64'({release_trigger, release_index}), 64'h0);
        chk("rst_flags", 64'({overflow, overrun, any_down}), 64'h0);

        // Idle: no keys for 10 ticks
        ticks(10);
        chk("idle_evt_valid", 64'(evt_valid), 64'h0);
        chk("idle_key_state", 64'(key_state), 64'h0);
        chk("idle_flags", 64'({overflow, overrun}), 64'h0);

        // Key 5 press and release
        keypad_matrix = 16'h0020;
        do_tick();
        chk("k5_after1", 64'(key_state), 64'h0);
        expect_evt(1'b1, 1'b0, 5);
        do_tick();
        chk("k5_down", 64'(key_state), 64'h0020);
        chk("k5_any_down", 64'(any_down), 64'h1);
        chk("k5_press_drained", 64'(exp_q.size()), 64'h0);
        rel0 = rel_cnt;
        keypad_matrix = '0;
        expect_evt(1'b0, 1'b0, 5);
        ticks(2);
        chk("k5_up", 64'(key_state), 64'h0);
        chk("k5_rel_pulses", 64'(rel_cnt - rel0), 64'h1);
        chk("k5_rel_index", 64'(release_index), 64'h5);
        chk("k5_rel_drained", 64'(exp_q.size()), 64'h0);

        // Glitch: one high sample must not flip; a second lone sample also must not
        keypad_matrix = 16'h0020;
        do_tick();
        keypad_matrix = '0;
        ticks(2);
        keypad_matrix = 16'h0020;
        do_tick();
        chk("glitch_key_state", 64'(key_state), 64'h0);
        keypad_matrix = '0;
        ticks(2);

        // Keys 3 and 9 together: ascending order
        expect_evt(1'b1, 1'b0, 3);
        expect_evt(1'b1, 1'b0, 9);
        keypad_matrix = 16'h0208;
        ticks(2);
        chk("k3k9_state", 64'(key_state), 64'h0208);
        chk("k3k9_drained", 64'(exp_q.size()), 64'h0);
        rel0 = rel_cnt;
        expect_evt(1'b0, 1'b0, 3);
        expect_evt(1'b0, 1'b0, 9);
        keypad_matrix = '0;
        ticks(2);
        chk("k3k9_rel_pulses", 64'(rel_cnt - rel0), 64'h2);
        chk("k3k9_rel_index", 64'(release_index), 64'h9);

        // Overflow: 6 presses into a 4-deep queue with no consumer
        chk("pre_ovf", 64'(overflow), 64'h0);
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) expect_evt(1'b1, 1'b0, i);
        keypad_matrix = 16'h003F;
        ticks(2);
        chk("ovf_flag", 64'(overflow), 64'h1);
        chk("ovf_state", 64'(key_state), 64'h003F);
        chk("ovf_valid", 64'(evt_valid), 64'h1);
        evt_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("ovf_drained", 64'(exp_q.size()), 64'h0);
        chk("ovf_empty", 64'(evt_valid), 64'h0);
        for (int i = 0; i < 6; i++) expect_evt(1'b0, 1'b0, i);
        keypad_matrix = '0;
        ticks(2);
        chk("ovf_rel_drained", 64'(exp_q.size()), 64'h0);
        chk("ovf_sticky", 64'(overflow), 64'h1);

        // Overrun: second tick three cycles into a sweep
        chk("pre_overrun", 64'(overrun), 64'h0);
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        repeat (3) @(posedge clk);
        #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        repeat (NUM_KEYS + 3) @(posedge clk);
        #1;
        chk("overrun_flag", 64'(overrun), 64'h1);
        chk("overrun_no_evt", 64'(evt_valid), 64'h0);

        // Reset mid-sweep clears sticky flags and partial debounce progress
        keypad_matrix = 16'h1000;
        do_tick();
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("midrst_flags", 64'({overflow, overrun}), 64'h0);
        chk("midrst_state", 64'(key_state), 64'h0);
        do_tick();
        chk("midrst_cnt_cleared", 64'(key_state), 64'h0);
        keypad_matrix = '0;
        ticks(2);

`ifdef KEYPAD_AUTOREPEAT_EN
        // Autorepeat: key 2 held for 44 ticks -> press, three repeats, release
        expect_evt(1'b1, 1'b0, 2);
        expect_evt(1'b1, 1'b1, 2);
        expect_evt(1'b1, 1'b1, 2);
        expect_evt(1'b1, 1'b1, 2);
        expect_evt(1'b0, 1'b0, 2);
        keypad_matrix = 16'h0004;
        ticks(44);
        keypad_matrix = '0;
        ticks(2);
        chk("rep_drained", 64'(exp_q.size()), 64'h0);
`endif

        chk("final_queue_empty", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
